// File: rtl/invaders_pkg.sv
// Shared state encoding and grid geometry helpers for the invader formation.
package invaders_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MARCH   = 2'd1,
    ST_CLEARED = 2'd2,
    ST_LANDED  = 2'd3
  } form_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Cell pitch along one axis: sprite extent plus the gap to the next cell.
  function automatic int pitch(input int size, input int gap);
    return size + gap;
  endfunction

endpackage

// File: rtl/invader_formation_extent.sv
// Combinational occupancy extents of the alive map: outermost alive columns,
// lowest alive row and whether anything is left alive.
module formation_extent
  import invaders_pkg::*;
#(
  parameter int ROWS = 5,
  parameter int COLS = 11,
  parameter int RW   = 3,
  parameter int CW   = 4
) (
  input  logic [ROWS*COLS-1:0] alive,
  output logic [CW-1:0]        lc,
  output logic [CW-1:0]        rc,
  output logic [RW-1:0]        br,
  output logic                 any_alive
);

  logic [COLS-1:0] col_any;
  logic [ROWS-1:0] row_any;

  // Fold the map into per-column and per-row occupancy.
  always_comb begin
    col_any = '0;
    row_any = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        col_any[c] = col_any[c] | alive[r*COLS+c];
        row_any[r] = row_any[r] | alive[r*COLS+c];
      end
    end
  end

  // Lowest/highest occupied column and highest occupied row (0 when empty).
  always_comb begin
    lc = '0;
    rc = '0;
    br = '0;
    for (int c = COLS - 1; c >= 0; c--) lc = col_any[c] ? CW'(c) : lc;
    for (int c = 0; c < COLS; c++)      rc = col_any[c] ? CW'(c) : rc;
    for (int r = 0; r < ROWS; r++)      br = row_any[r] ? RW'(r) : br;
  end

  assign any_alive = |col_any;

endmodule

// File: rtl/invader_formation.sv
// Invader grid: marches, descends at the outermost alive column, takes hits and
// flags cleared/landed. Define INVADER_SPEEDUP_EN to shorten the step period as the grid thins.
module invader_formation
  import invaders_pkg::*;
#(
  parameter int ROWS        = 5,
  parameter int COLS        = 11,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int GAP_X       = 8,
  parameter int GAP_Y       = 8,
  parameter int STEP_X      = 2,
  parameter int STEP_Y      = 8,
  parameter int START_X     = 40,
  parameter int START_Y     = 48,
  parameter int LEFT_BOUND  = 0,
  parameter int RIGHT_BOUND = SCREEN_W - 1,
  parameter int LAND_Y      = 400,
  parameter int MOVE_DIV    = 4
) (
  input  logic                             frame_clk,
  input  logic                             Reset,
  input  logic                             start,
  input  logic                             hit_valid,
  input  logic [$clog2(ROWS)-1:0]          hit_row,
  input  logic [$clog2(COLS)-1:0]          hit_col,
  output logic [9:0]                       form_x,
  output logic [9:0]                       form_y,
  output logic [ROWS*COLS-1:0]             alive,
  output logic [$clog2(ROWS*COLS+1)-1:0]   alive_count,
  output logic                             direction,
  output logic                             cleared,
  output logic                             landed
);

  localparam int N    = ROWS * COLS;
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);
  localparam int CNTW = $clog2(N + 1);
  localparam int TW   = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int PX   = pitch(SPRITE_W, GAP_X);
  localparam int PY   = pitch(SPRITE_H, GAP_Y);
  localparam logic [10:0] RB      = 11'(RIGHT_BOUND);
  localparam logic [10:0] LB_STEP = 11'(LEFT_BOUND + STEP_X);
  localparam logic [10:0] STEP11  = 11'(STEP_X);
  localparam logic [10:0] LAND_B  = 11'(LAND_Y);

  form_state_t       state, state_nxt;
  logic [9:0]        x_nxt, y_nxt;
  logic [N-1:0]      alive_nxt, hit_mask;
  logic [CNTW-1:0]   count_nxt;
  logic              dir_nxt, cleared_nxt, landed_nxt;
  logic [TW-1:0]     tick, tick_nxt;
  logic [TW:0]       period, period_next;
  logic              descended, desc_nxt, fire;
  logic [CW-1:0]     lc, rc;
  logic [RW-1:0]     br;
  logic              any_alive;
  logic [10:0]       left_edge, right_edge, bottom;

  formation_extent #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) u_extent (
    .alive     (alive),
    .lc        (lc),
    .rc        (rc),
    .br        (br),
    .any_alive (any_alive)
  );

  // Edges are widened to 11 bits so that the bound comparisons never wrap.
  assign left_edge  = {1'b0, form_x} + 11'(lc) * 11'(PX);
  assign right_edge = {1'b0, form_x} + 11'(rc) * 11'(PX) + 11'(SPRITE_W - 1);
  assign bottom     = {1'b0, form_y} + 11'(br) * 11'(PY) + 11'(SPRITE_H - 1);

`ifdef INVADER_SPEEDUP_EN
  function automatic logic [TW:0] period_of(input logic [CNTW-1:0] cnt);
    if (int'(cnt) > N / 2)      return (TW+1)'(MOVE_DIV);
    else if (int'(cnt) > N / 4) return (TW+1)'((MOVE_DIV / 2 > 1) ? MOVE_DIV / 2 : 1);
    else if (int'(cnt) > 1)     return (TW+1)'((MOVE_DIV / 4 > 1) ? MOVE_DIV / 4 : 1);
    else                        return (TW+1)'(1);
  endfunction
  assign period      = period_of(alive_count);
  assign period_next = period_of(count_nxt);
`else
  assign period      = (TW+1)'(MOVE_DIV);
  assign period_next = period;
`endif

  assign fire = ({1'b0, tick} == period - (TW+1)'(1));

  // One-hot decode of the hit coordinates; out-of-range indices decode to nothing.
  always_comb begin
    hit_mask = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        hit_mask[r*COLS+c] = hit_valid && (hit_row == RW'(r)) && (hit_col == CW'(c));
      end
    end
  end

  // Next-state: start/init, hits, clear/land detection and the march step.
  always_comb begin
    state_nxt   = state;
    x_nxt       = form_x;
    y_nxt       = form_y;
    alive_nxt   = alive;
    count_nxt   = alive_count;
    dir_nxt     = direction;
    cleared_nxt = cleared;
    landed_nxt  = landed;
    desc_nxt    = 1'b0;
    case (state)
      ST_MARCH: begin
        if (|(hit_mask & alive)) begin
          alive_nxt = alive & ~hit_mask;
          count_nxt = alive_count - CNTW'(1);
        end else begin
          alive_nxt = alive;
        end
        // Steps use the extents of the map as registered, i.e. before this cycle's hit.
        if (alive_count == '0) begin
          state_nxt   = ST_CLEARED;
          cleared_nxt = 1'b1;
        end else if (descended && bottom >= LAND_B) begin
          state_nxt  = ST_LANDED;
          landed_nxt = 1'b1;
        end else if (fire && any_alive) begin
          if (direction) begin
            if (right_edge + STEP11 > RB) begin
              y_nxt    = form_y + 10'(STEP_Y);
              dir_nxt  = 1'b0;
              desc_nxt = 1'b1;
            end else begin
              x_nxt = form_x + 10'(STEP_X);
            end
          end else begin
            if (left_edge < LB_STEP) begin
              y_nxt    = form_y + 10'(STEP_Y);
              dir_nxt  = 1'b1;
              desc_nxt = 1'b1;
            end else begin
              x_nxt = form_x - 10'(STEP_X);
            end
          end
        end else begin
          state_nxt = ST_MARCH;
        end
      end
      ST_IDLE, ST_CLEARED, ST_LANDED: begin
        if (start) begin
          state_nxt   = ST_MARCH;
          x_nxt       = 10'(START_X);
          y_nxt       = 10'(START_Y);
          alive_nxt   = '1;
          count_nxt   = CNTW'(N);
          dir_nxt     = 1'b1;
          cleared_nxt = 1'b0;
          landed_nxt  = 1'b0;
        end else begin
          state_nxt = state;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Tick counter: wraps on a step and restarts whenever the march period changes.
  always_comb begin
    if (state == ST_MARCH) begin
      tick_nxt = (fire || (period_next != period)) ? '0 : tick + TW'(1);
    end else begin
      tick_nxt = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state       <= ST_IDLE;
      form_x      <= 10'(START_X);
      form_y      <= 10'(START_Y);
      alive       <= '0;
      alive_count <= '0;
      direction   <= 1'b1;
      cleared     <= 1'b0;
      landed      <= 1'b0;
      tick        <= '0;
      descended   <= 1'b0;
    end else begin
      state       <= state_nxt;
      form_x      <= x_nxt;
      form_y      <= y_nxt;
      alive       <= alive_nxt;
      alive_count <= count_nxt;
      direction   <= dir_nxt;
      cleared     <= cleared_nxt;
      landed      <= landed_nxt;
      tick        <= tick_nxt;
      descended   <= desc_nxt;
    end
  end

endmodule

// File: tb/tb_invader_formation.sv
// Scoreboard bench for invader_formation: a per-frame reference model pushes
// expected outputs, a monitor compares them; a second instance covers landing.
module tb_invader_formation;

  localparam int ROWS = 5, COLS = 11, N = ROWS * COLS;
  localparam int SW = 16, SH = 16, PX = 24, PY = 24;
  localparam int STEP_X = 2, STEP_Y = 8, START_X = 40, START_Y = 48;
  localparam int LEFT_B = 0, RIGHT_B = 639, LAND_Y = 400, MOVE_DIV = 4;
  localparam int S_IDLE = 0, S_MARCH = 1, S_CLR = 2, S_LAND = 3;

  logic frame_clk = 1'b0;
  logic Reset = 1'b1, start = 1'b0, hit_valid = 1'b0;
  logic [2:0] hit_row = 3'd0;
  logic [3:0] hit_col = 4'd0;
  logic [9:0] form_x, form_y;
  logic [N-1:0] alive;
  logic [5:0] alive_count;
  logic direction, cleared, landed;

  logic land_start = 1'b0;
  logic [9:0] l_x, l_y;
  logic [N-1:0] l_alive;
  logic [5:0] l_count;
  logic l_dir, l_cleared, l_landed;

  invader_formation dut (
    .frame_clk(frame_clk), .Reset(Reset), .start(start), .hit_valid(hit_valid),
    .hit_row(hit_row), .hit_col(hit_col), .form_x(form_x), .form_y(form_y),
    .alive(alive), .alive_count(alive_count), .direction(direction),
    .cleared(cleared), .landed(landed)
  );

  invader_formation #(.LAND_Y(167), .MOVE_DIV(1), .START_X(380)) dut_land (
    .frame_clk(frame_clk), .Reset(Reset), .start(land_start), .hit_valid(1'b0),
    .hit_row(3'd0), .hit_col(4'd0), .form_x(l_x), .form_y(l_y),
    .alive(l_alive), .alive_count(l_count), .direction(l_dir),
    .cleared(l_cleared), .landed(l_landed)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int x; int y; logic [N-1:0] alv; int count; int dir; int clr; int lnd;
  } exp_t;
  exp_t exp_q[$];
  int vectors = 0, miscompares = 0;

  // Reference model of the formation, one call per frame.
  int m_state, m_x, m_y, m_dir, m_tick, m_count;
  bit m_pend;
  bit m_alive[ROWS][COLS];

  function automatic int period_of(input int cnt);
`ifdef INVADER_SPEEDUP_EN
    if (cnt > N / 2) return MOVE_DIV;
    else if (cnt > N / 4) return (MOVE_DIV / 2 > 1) ? MOVE_DIV / 2 : 1;
    else if (cnt > 1) return (MOVE_DIV / 4 > 1) ? MOVE_DIV / 4 : 1;
    else return 1;
`else
    return (cnt >= 0) ? MOVE_DIV : MOVE_DIV;
`endif
  endfunction

  task automatic model_step(input bit rst, input bit st, input bit hv, input int hr, input int hc);
    int per_old, lc, rc, br, cur_count, nb;
    bit fire, pend;
    if (rst) begin
      m_state = S_IDLE; m_x = START_X; m_y = START_Y; m_dir = 1;
      m_tick = 0; m_count = 0; m_pend = 0;
      foreach (m_alive[r, c]) m_alive[r][c] = 0;
    end else if (m_state != S_MARCH) begin
      if (st) begin
        m_state = S_MARCH; m_x = START_X; m_y = START_Y; m_dir = 1;
        m_tick = 0; m_count = N; m_pend = 0;
        foreach (m_alive[r, c]) m_alive[r][c] = 1;
      end
    end else begin
      per_old = period_of(m_count);
      fire = (m_tick == per_old - 1);
      lc = COLS; rc = -1;
      foreach (m_alive[r, c]) if (m_alive[r][c]) begin
        if (c < lc) lc = c;
        if (c > rc) rc = c;
      end
      cur_count = m_count;
      pend = m_pend;
      m_pend = 0;
      if (hv && hr < ROWS && hc < COLS && m_alive[hr][hc]) begin
        m_alive[hr][hc] = 0;
        m_count--;
      end
      if (cur_count == 0) m_state = S_CLR;
      else if (pend) m_state = S_LAND;
      else if (fire && rc >= 0) begin
        if ((m_dir == 1 && m_x + rc * PX + SW - 1 + STEP_X > RIGHT_B) ||
            (m_dir == 0 && m_x + lc * PX < LEFT_B + STEP_X)) begin
          m_y = (m_y + STEP_Y) & 1023;
          m_dir = 1 - m_dir;
          br = -1;
          foreach (m_alive[r, c]) if (m_alive[r][c] && r > br) br = r;
          nb = m_y + br * PY + SH - 1;
          m_pend = (nb >= LAND_Y);
        end else if (m_dir == 1) m_x = (m_x + STEP_X) & 1023;
        else m_x = (m_x - STEP_X) & 1023;
      end
      m_tick = (fire || period_of(m_count) != per_old) ? 0 : m_tick + 1;
    end
  endtask

  task automatic cycle(input bit rst, input bit st, input bit hv, input int hr, input int hc);
    exp_t e;
    @(negedge frame_clk);
    Reset = rst; start = st; hit_valid = hv;
    hit_row = hr[2:0]; hit_col = hc[3:0];
    model_step(rst, st, hv, hr, hc);
    e.x = m_x; e.y = m_y; e.count = m_count; e.dir = m_dir;
    e.clr = (m_state == S_CLR); e.lnd = (m_state == S_LAND);
    foreach (m_alive[r, c]) e.alv[r*COLS+c] = m_alive[r][c];
    exp_q.push_back(e);
  endtask

  // Monitor: compares every registered output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge frame_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (int'(form_x) != e.x || int'(form_y) != e.y || alive !== e.alv ||
            int'(alive_count) != e.count || int'(direction) != e.dir ||
            int'(cleared) != e.clr || int'(landed) != e.lnd) begin
          miscompares++;
          $display("FAIL vec%0d got/exp: x=%0d/%0d y=%0d/%0d alive=%h/%h count=%0d/%0d dir=%0d/%0d cleared=%0d/%0d landed=%0d/%0d",
                   vectors, form_x, e.x, form_y, e.y, alive, e.alv, alive_count, e.count,
                   direction, e.dir, cleared, e.clr, landed, e.lnd);
        end
      end
    end
  end

  task automatic check_land(input int k, input int ex, input int ey, input int el, input int ed);
    vectors++;
    if (int'(l_x) != ex || int'(l_y) != ey || int'(l_landed) != el || int'(l_dir) != ed) begin
      miscompares++;
      $display("FAIL land%0d got/exp: x=%0d/%0d y=%0d/%0d landed=%0d/%0d dir=%0d/%0d",
               k, l_x, ex, l_y, ey, l_landed, el, l_dir, ed);
    end
  endtask

  initial begin
    int lx[9] = '{380, 382, 384, 384, 384, 384, 384, 384, 384};
    int ly[9] = '{48, 48, 48, 56, 56, 56, 56, 56, 56};
    int ll[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
    int ld[9] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
    bit hv, st;

    repeat (3) cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 2, 3);
    cycle(0, 1, 0, 0, 0);
    repeat (720) cycle(0, 0, 0, 0, 0);
    for (int r = 0; r < ROWS; r++) cycle(0, 0, 1, r, 10);
    cycle(0, 0, 1, 0, 10);
    repeat (1800) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 7, 2);
    cycle(0, 0, 1, 1, 15);
    repeat (3000) begin
      hv = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 63) == 0);
      cycle(0, st, hv, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
    end
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) cycle(0, 0, 1, r, c);
    repeat (6) cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    repeat (20) cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    repeat (10) cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 1, 1, 1);
    repeat (4) cycle(0, 0, 0, 0, 0);

    repeat (20) begin
      if (exp_q.size() == 0) break;
      @(posedge frame_clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    @(negedge frame_clk);
    land_start = 1'b1;
    @(posedge frame_clk);
    #1;
    check_land(0, lx[0], ly[0], ll[0], ld[0]);
    land_start = 1'b0;
    for (int k = 1; k < 9; k++) begin
      @(posedge frame_clk);
      #1;
      check_land(k, lx[k], ly[k], ll[k], ld[k]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/invader_formation.md
Name: invader_formation

Overview:
Parametrised successor to the single-sprite enemy block; owns the position and alive map of a ROWS x COLS grid of invaders marching as one unit.
- Marches horizontally; at the playfield edge it steps down and reverses.
- Edge detection uses the outermost alive columns only.
- Accepts hit reports from the collision logic.
- Flags cleared and landed conditions to the game controller.
- Updates once per frame_clk; the per-pixel renderer reads form_x/form_y/alive to draw.

Parameters:
ROWS, 5, invader rows
COLS, 11, invader columns
SPRITE_W, 16, sprite width px
SPRITE_H, 16, sprite height px
GAP_X, 8, horizontal gap px (pitch PX = SPRITE_W+GAP_X)
GAP_Y, 8, vertical gap px (pitch PY = SPRITE_H+GAP_Y)
STEP_X, 2, px per march step
STEP_Y, 8, px per descend
START_X, 40, formation origin x at start
START_Y, 48, formation origin y at start
LEFT_BOUND, 0, leftmost legal px
RIGHT_BOUND, 639, rightmost legal px
LAND_Y, 400, bottom px at or beyond which the formation has landed
MOVE_DIV, 4, frames per step (>=1)

Ports:
frame_clk  in  1  frame-rate clock
Reset  in  1  synchronous, active-high
start  in  1  (re)initialise formation
hit_valid  in  1  one-cycle hit report
hit_row  in  $clog2(ROWS)  hit row index
hit_col  in  $clog2(COLS)  hit column index
form_x  out  10  origin x of cell (0,0)
form_y  out  10  origin y of cell (0,0)
alive  out  ROWS*COLS  bit r*COLS+c = invader (r,c) alive
alive_count  out  $clog2(ROWS*COLS+1)  number of alive invaders
direction  out  1  1=right, 0=left
cleared  out  1  all invaders dead
landed  out  1  formation reached LAND_Y

Behaviour:
- Reset values: state IDLE, form_x=START_X, form_y=START_Y, alive=0, alive_count=0, direction=1, cleared=0, landed=0, tick counter=0.
- States: IDLE, MARCH, CLEARED, LANDED.
- start accepted in IDLE/CLEARED/LANDED; ignored in MARCH.
- On start: alive=all ones, alive_count=ROWS*COLS, origin=START, direction=1, counter=0, flags cleared, state MARCH.
- Tick: counter increments each cycle in MARCH; step fires when counter==period-1, then counter wraps to 0. period=MOVE_DIV.
- Extents, from the alive map as registered at cycle start:
  - Lc/Rc = lowest/highest column with any alive bit.
  - Br = highest row with any alive bit.
  - left edge = form_x+Lc*PX.
  - right edge = form_x+Rc*PX+SPRITE_W-1.
  - bottom = form_y+Br*PY+SPRITE_H-1.
- Step, direction=1:
  - If right edge+STEP_X > RIGHT_BOUND: descend (form_y+=STEP_Y, direction toggles, form_x unchanged).
  - Else form_x+=STEP_X.
- Step, direction=0: mirror rule; descend if left edge < LEFT_BOUND+STEP_X, else form_x-=STEP_X.
- Landing: after a descend, if the new bottom >= LAND_Y, go to LANDED next cycle; landed=1, motion frozen.
- Hits:
  - A hit_valid with in-range indices on an alive bit clears that bit and decrements alive_count in the same edge.
  - Dead-cell and out-of-range hits are ignored.
  - Hits are accepted only in MARCH.
- Simultaneous hit and step: both apply; the step uses pre-hit extents.
- Clear: when alive_count transitions to 0, state goes to CLEARED next cycle; cleared=1, no further steps. Clear takes precedence over landing in the same cycle.
- Arithmetic: coordinates are 10-bit unsigned; all edge sums are computed at 11 bits to avoid wrap.
- Reset mid-operation restores all reset values on the next edge.

Optional Feature:
INVADER_SPEEDUP_EN:
- Defined: period tracks alive_count, using integer divides, minimum 1.
  - alive_count > N/2: period = MOVE_DIV.
  - alive_count > N/4: period = MOVE_DIV/2.
  - alive_count > 1: period = MOVE_DIV/4.
  - alive_count == 1: period = 1.
  - Counter resets to 0 whenever the period changes.
- Undefined: period is fixed at MOVE_DIV.

Decomposition:
- Package invaders_pkg: state enum, PX/PY localparam functions, default screen bounds (640x480).
- One sub-module, formation_extent (combinational): alive map -> Lc, Rc, Br, any_alive.

Test Plan:
- Reset, then start pulse: alive=55 ones, alive_count=55, form_x=40; 4 cycles later form_x=42.
- March right uninterrupted: after 172 steps form_x=384 (right edge 639); step 173 gives form_y=56, direction=0, form_x=384.
- Kill column 10 (5 hits), then repeat a hit on (0,10): alive_count=50, not 49; right edge shrinks 24 px; descend now triggers at form_x=408.
- LAND_Y=167, MOVE_DIV=1, start near RIGHT_BOUND: first descend gives form_y=56, bottom 167, landed=1, form_x/form_y frozen thereafter.
- Kill all 55 (one hit per cycle): cleared=1 one cycle after the last hit, steps stop; start restarts with alive_count=55.
- Reset asserted mid-MARCH with hit_valid high: next edge alive=0, form_x=40, form_y=48, direction=1, flags 0.
